// File: rtl/keypad_scanner_if.sv
// Keypad pins and decoded-key outputs of the 4x4 keypad scanner.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row, key_code, key_valid, key_held
    );

    modport slave (
        output col,
        input  row, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce.
// Emits a one-cycle key_valid pulse per newly accepted key press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    keypad_scanner_if.master  kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_SCANS);
    localparam bit            DB_ONE    = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    logic [3:0]    r_sync1, r_sync2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_row_idx;
    logic [1:0]    r_nseen;
    logic [3:0]    r_acc_code;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_key_valid;

    logic [3:0]    w_low;
    logic [2:0]    w_nlow;
    logic [1:0]    w_col_idx;
    logic          w_sample;
    logic          w_frame_end;
    logic [2:0]    w_sum;
    logic [1:0]    w_tot;
    logic [3:0]    w_code;
    logic          w_none;
    logic          w_key;
    logic [CW-1:0] w_cnt_inc;
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_cand_nxt;
    logic [3:0]    w_code_nxt;
    logic          w_valid_nxt;

    assign w_low  = ~r_sync2;
    assign w_nlow = {2'b0, w_low[0]} + {2'b0, w_low[1]}
                  + {2'b0, w_low[2]} + {2'b0, w_low[3]};

    always_comb begin
        w_col_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (w_low[i]) w_col_idx = 2'(i);
        end
    end

    assign w_sample    = (r_dwell == DWELL_END);
    assign w_frame_end = w_sample && (r_row_idx == 2'd3);

    // Low-bit tally saturates at 2: anything beyond one press is MULTI
    assign w_sum  = {1'b0, r_nseen}
                  + ((w_nlow > 3'd1) ? 3'd2 : w_nlow);
    assign w_tot  = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
    assign w_code = (w_nlow == 3'd1) ? {r_row_idx, w_col_idx}
                                     : r_acc_code;
    assign w_none = (w_tot == 2'd0);
    assign w_key  = (w_tot == 2'd1);

    assign w_cnt_inc = (r_cnt == DB_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1    <= 4'hF;
            r_sync2    <= 4'hF;
            r_dwell    <= '0;
            r_row_idx  <= '0;
            r_nseen    <= '0;
            r_acc_code <= '0;
        end else begin
            r_sync1 <= kp.col;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_dwell   <= '0;
                r_row_idx <= r_row_idx + 1'b1;
                if (r_row_idx == 2'd3) begin
                    r_nseen    <= '0;
                    r_acc_code <= '0;
                end else begin
                    r_nseen    <= w_tot;
                    r_acc_code <= w_code;
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand      <= w_cand_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        if (w_frame_end) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_key) begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = CW'(1);
                        if (DB_ONE) begin
                            w_state_nxt = S_HELD;
                            w_code_nxt  = w_code;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_PRESS_DB;
                        end
                    end
                end
                S_PRESS_DB: begin
                    if (w_key && (w_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DB_MAX) begin
                            w_state_nxt = S_HELD;
                            w_code_nxt  = r_cand;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (w_key) begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = CW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_HELD: begin
                    if (w_none) begin
                        if (DB_ONE) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_REL_DB;
                            w_cnt_nxt   = CW'(1);
                        end
                    end
                end
                S_REL_DB: begin
                    if (w_none) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DB_MAX) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign kp.row       = ~(4'b0001 << r_row_idx);
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = (r_state == S_HELD) || (r_state == S_REL_DB);
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level reference model plus directed
// keypad scenarios with hand-computed expectations.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 2;
    localparam int FR = 4 * SD;

    logic        clk   = 1'b0;
    logic        clr_n = 1'b0;
    logic [15:0] keys  = '0;

    int nchk   = 0;
    int nerr   = 0;
    int npulse = 0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Ideal matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        kif.col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.row[r] && keys[r*4+c]) kif.col[c] = 1'b0;
            end
        end
    end

    // Reference model: cycle counter since reset, one decision per frame
    int          m_n;
    logic        m_valid;
    logic        m_held;
    logic [3:0]  m_code;
    int          m_hist [DB-1];
    logic [3:0]  m_row;

    function automatic int frame_res(input logic [15:0] k);
        int n   = 0;
        int idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                idx = i;
            end
        end
        if (n == 0) return -1;
        if (n == 1) return idx;
        return -2;
    endfunction

    function automatic bit run_of(input int cur);
        bit ok = 1'b1;
        for (int i = 0; i < DB - 1; i++) begin
            if (m_hist[i] != cur) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb m_row = 4'b1111 ^ (4'b0001 << ((m_n / SD) % 4));

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_n     <= 0;
            m_valid <= 1'b0;
            m_held  <= 1'b0;
            m_code  <= '0;
            for (int i = 0; i < DB - 1; i++) m_hist[i] <= -3;
        end else begin
            m_n     <= m_n + 1;
            m_valid <= 1'b0;
            if ((m_n + 1) % FR == 0) begin
                if (!m_held && frame_res(keys) >= 0
                    && run_of(frame_res(keys))) begin
                    m_held  <= 1'b1;
                    m_valid <= 1'b1;
                    m_code  <= 4'(frame_res(keys));
                end else if (m_held && frame_res(keys) == -1
                             && run_of(-1)) begin
                    m_held <= 1'b0;
                end
                m_hist[0] <= frame_res(keys);
                for (int i = 1; i < DB - 1; i++) m_hist[i] <= m_hist[i-1];
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic frames(input int f);
        repeat (f) begin
            @(negedge clk);
            while (m_n % FR != 0) @(negedge clk);
        end
        #1;
    endtask

    logic [3:0] rowtab [4];
    int         p0;

    initial begin
        rowtab = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        fork
            forever begin
                @(negedge clk);
                if (kif.key_valid) npulse++;
                chk("cyc_row",   {12'b0, kif.row},      {12'b0, m_row});
                chk("cyc_valid", {15'b0, kif.key_valid}, {15'b0, m_valid});
                chk("cyc_held",  {15'b0, kif.key_held},  {15'b0, m_held});
                chk("cyc_code",  {12'b0, kif.key_code},  {12'b0, m_code});
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("rst_row",   {12'b0, kif.row},       16'h000E);
                chk("rst_valid", {15'b0, kif.key_valid}, 16'h0000);
                chk("rst_held",  {15'b0, kif.key_held},  16'h0000);
                chk("rst_code",  {12'b0, kif.key_code},  16'h0000);
                @(negedge clk);
                clr_n = 1'b1;
                @(negedge clk);
                #1;
                chk("row_n1", {12'b0, kif.row}, 16'h000E);
                for (int s = 0; s < 4; s++) begin
                    repeat (4) @(negedge clk);
                    #1;
                    chk("row_seq", {12'b0, kif.row}, {12'b0, rowtab[s]});
                end
                frames(1);

                keys = 16'h0040;
                p0 = npulse;
                frames(3);
                chk("press6_pulses", 16'(npulse - p0), 16'd1);
                chk("press6_code", {12'b0, kif.key_code}, 16'h0006);
                chk("press6_held", {15'b0, kif.key_held}, 16'h0001);
                p0 = npulse;
                frames(10);
                chk("hold6_pulses", 16'(npulse - p0), 16'd0);

                keys = '0;
                frames(1);
                chk("glitch_held", {15'b0, kif.key_held}, 16'h0001);
                keys = 16'h0040;
                frames(2);
                chk("glitch_pulses", 16'(npulse - p0), 16'd0);
                chk("glitch_held2", {15'b0, kif.key_held}, 16'h0001);

                keys = '0;
                frames(1);
                chk("rel1_held", {15'b0, kif.key_held}, 16'h0001);
                frames(1);
                chk("rel2_held", {15'b0, kif.key_held}, 16'h0000);
                chk("rel_code", {12'b0, kif.key_code}, 16'h0006);
                chk("rel_pulses", 16'(npulse - p0), 16'd0);

                keys = 16'h8000;
                frames(1);
                keys = '0;
                frames(3);
                chk("bounceF_pulses", 16'(npulse - p0), 16'd0);
                chk("bounceF_held", {15'b0, kif.key_held}, 16'h0000);
                keys = 16'h0001;
                frames(1);
                keys = 16'h0020;
                frames(2);
                chk("chg5_pulses", 16'(npulse - p0), 16'd1);
                chk("chg5_code", {12'b0, kif.key_code}, 16'h0005);
                keys = '0;
                frames(3);

                keys = 16'h0012;
                p0 = npulse;
                frames(5);
                chk("multi_pulses", 16'(npulse - p0), 16'd0);
                chk("multi_held", {15'b0, kif.key_held}, 16'h0000);
                keys = 16'h0002;
                frames(2);
                chk("multi_k1_pulses", 16'(npulse - p0), 16'd1);
                chk("multi_k1_code", {12'b0, kif.key_code}, 16'h0001);
                keys = '0;
                frames(3);

                keys = 16'h0200;
                p0 = npulse;
                frames(3);
                chk("k9_pulses", 16'(npulse - p0), 16'd1);
                chk("k9_held", {15'b0, kif.key_held}, 16'h0001);
                repeat (6) @(posedge clk);
                #2;
                clr_n = 1'b0;
                #1;
                chk("arst_row",   {12'b0, kif.row},       16'h000E);
                chk("arst_held",  {15'b0, kif.key_held},  16'h0000);
                chk("arst_valid", {15'b0, kif.key_valid}, 16'h0000);
                chk("arst_code",  {12'b0, kif.key_code},  16'h0000);
                repeat (3) @(negedge clk);
                clr_n = 1'b1;
                p0 = npulse;
                frames(3);
                chk("rek9_pulses", 16'(npulse - p0), 16'd1);
                chk("rek9_code", {12'b0, kif.key_code}, 16'h0009);
                chk("rek9_held", {15'b0, kif.key_held}, 16'h0001);
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
